// File: rtl/cla_sub_pipe.sv
// ---------------------------------------------------------------------------
// cla_sub_pipe
//   16-bit two-stage pipelined subtractor producing D = A - B - BIN together
//   with an unsigned borrow-out and a signed overflow flag. The arithmetic is
//   the carry-lookahead adder path fed with A + ~B + ~BIN, built from 4-bit
//   lookahead groups. The carry chain is cut at bit 8: stage 1 resolves the
//   low byte, stage 2 resolves the high byte and the flags. Both sides use a
//   valid/ready handshake, and the pipeline stalls without losing beats.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   in_valid   in   1   operand beat valid
//   in_ready   out  1   block accepts a beat this cycle
//   a          in   16  minuend
//   b          in   16  subtrahend
//   bin        in   1   borrow-in
//   out_valid  out  1   result beat valid
//   out_ready  in   1   consumer accepts the result this cycle
//   d          out  16  difference, A - B - BIN mod 2^16
//   bout       out  1   borrow-out (1 when A < B + BIN, unsigned)
//   ovf        out  1   signed overflow
// ---------------------------------------------------------------------------
module cla_sub_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] d,
    output logic        bout,
    output logic        ovf
);

    // 4-bit carry-lookahead group: returns {carry-out, sum[3:0]}.
    // Every internal carry is a flat sum of products of generate/propagate
    // terms, so no carry ripples inside the group.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Stage 1 registers: low byte result, carry into bit 8, and the high
    // operand bytes (subtrahend already inverted) for stage 2.
    logic        r_s1_valid;
    logic [7:0]  r_s1_dlo;
    logic        r_s1_c8;
    logic [7:0]  r_s1_ahi;
    logic [7:0]  r_s1_nbhi;
    logic        r_s1_a15;
    logic        r_s1_b15;

    // Stage 2 registers drive the outputs directly.
    logic        r_s2_valid;
    logic [15:0] r_d;
    logic        r_bout;
    logic        r_ovf;

    logic [15:0] w_nb;
    logic [4:0]  w_lo0;
    logic [4:0]  w_lo1;
    logic [4:0]  w_hi0;
    logic [4:0]  w_hi1;
    logic [7:0]  w_dhi;
    logic        w_bout;
    logic        w_ovf;
    logic        w_adv2;
    logic        w_accept;
    logic        w_s1_valid_next;
    logic        w_s2_valid_next;

    // Low byte: subtraction as addition of the inverted subtrahend, with the
    // borrow-in turned into an inverted carry-in.
    always_comb begin
        w_nb  = ~b;
        w_lo0 = cla4(a[3:0], w_nb[3:0], ~bin);
        w_lo1 = cla4(a[7:4], w_nb[7:4], w_lo0[4]);
    end

    // High byte and flags from the stage-1 snapshot. A carry out of bit 15
    // means no borrow. Overflow happens only when the operand signs differ
    // and the result sign disagrees with the minuend.
    always_comb begin
        w_hi0  = cla4(r_s1_ahi[3:0], r_s1_nbhi[3:0], r_s1_c8);
        w_hi1  = cla4(r_s1_ahi[7:4], r_s1_nbhi[7:4], w_hi0[4]);
        w_dhi  = {w_hi1[3:0], w_hi0[3:0]};
        w_bout = ~w_hi1[4];
        w_ovf  = (r_s1_a15 != r_s1_b15) && (w_dhi[7] != r_s1_a15);
    end

    // Stage-advance rule. Stage 2 reloads when it is empty or its beat is
    // being consumed. Stage 1 accepts whenever it will be vacated, which lets
    // a full pipeline shift and take a new beat on the same edge.
    always_comb begin
        w_adv2          = r_s1_valid && (!r_s2_valid || out_ready);
        in_ready        = !r_s1_valid || w_adv2;
        w_accept        = in_valid && in_ready;
        w_s1_valid_next = w_accept || (r_s1_valid && !w_adv2);
        w_s2_valid_next = w_adv2 || (r_s2_valid && !out_ready);
    end

    // Stage 1 captures operands only on an accepted beat, so the inputs are
    // free to change at any other time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_dlo   <= '0;
            r_s1_c8    <= 1'b0;
            r_s1_ahi   <= '0;
            r_s1_nbhi  <= '0;
            r_s1_a15   <= 1'b0;
            r_s1_b15   <= 1'b0;
        end else begin
            r_s1_valid <= w_s1_valid_next;
            if (w_accept) begin
                r_s1_dlo  <= {w_lo1[3:0], w_lo0[3:0]};
                r_s1_c8   <= w_lo1[4];
                r_s1_ahi  <= a[15:8];
                r_s1_nbhi <= w_nb[15:8];
                r_s1_a15  <= a[15];
                r_s1_b15  <= b[15];
            end
        end
    end

    // Stage 2 loads only on advance, so a stalled result stays bit-stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_d        <= '0;
            r_bout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_s2_valid <= w_s2_valid_next;
            if (w_adv2) begin
                r_d    <= {w_dhi, r_s1_dlo};
                r_bout <= w_bout;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign d         = r_d;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_sub_pipe
//   Self-checking bench for cla_sub_pipe: a table of hand-computed single
//   beats with latency checks, a back-to-back stream, a stalled stream and a
//   reset with both stages full. A negedge monitor keeps a scoreboard of
//   accepted beats (reference model) and an occupancy-based in_ready model.
// ---------------------------------------------------------------------------
module tb_cla_sub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        bout;
    logic        ovf;

    cla_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t        vecs[12];
    logic [17:0] expQ[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          outCount   = 0;
    bit          monEn      = 1'b0;

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {bout,d} = {1'b0,a} - b - bin; returns {ovf,bout,d}.
    function automatic logic [17:0] refModel(input logic [15:0] x,
                                             input logic [15:0] y,
                                             input logic        bi);
        logic [16:0] r;
        logic        v;
        r = {1'b0, x} - {1'b0, y} - {16'd0, bi};
        v = (x[15] != y[15]) && (r[15] != x[15]);
        return {v, r[16], r[15:0]};
    endfunction

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor at negedge: inputs and handshake are stable for the coming
    // edge. in_ready is predicted from the number of beats in flight.
    always @(negedge clk) begin
        if (monEn) begin
            if (!rst_n) begin
                expQ.delete();
            end else begin
                checkOutput("in_ready_model", {31'd0, in_ready},
                            {31'd0, (expQ.size() < 2) || out_ready});
                if (out_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_out_valid", 32'd1, 32'd0);
                    end else begin
                        checkOutput("result", {14'd0, ovf, bout, d},
                                    {14'd0, expQ[0]});
                        if (out_ready) begin
                            void'(expQ.pop_front());
                            outCount++;
                        end
                    end
                end
                if (in_valid && in_ready) expQ.push_back(refModel(a, b, bin));
            end
        end
    end

    // One beat from the table, with latency checks at N+1, N+2 and N+3.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        bin       = v.bin;
        #1;
        checkOutput($sformatf("vec%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        bin      = 1'($urandom);
        #1;
        checkOutput($sformatf("vec%0d_valid_n1", idx), {31'd0, out_valid}, 32'd0);
        @(posedge clk); #2;
        checkOutput($sformatf("vec%0d_valid_n2", idx), {31'd0, out_valid}, 32'd1);
        checkOutput($sformatf("vec%0d_result", idx), {14'd0, ovf, bout, d},
                    {14'd0, v.ovf, v.bout, v.d});
        @(posedge clk); #2;
        checkOutput($sformatf("vec%0d_valid_n3", idx), {31'd0, out_valid}, 32'd0);
    endtask

    // Drive n beats, holding each until accepted; out_ready is low for the
    // cycles in [stallStart, stallStart+stallLen). Returns cycles used.
    task automatic runStream(input int n, input int stallStart, input int stallLen,
                             input logic [15:0] offA, output int cyc);
        int  idx;
        bit  acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= stallStart && cyc < stallStart + stallLen);
            in_valid  = 1'b1;
            a         = 16'(idx * 16'h1111) + offA;
            b         = 16'(idx);
            bin       = 1'b0;
            @(negedge clk);
            acc = in_ready;
            cyc++;
            if (acc) idx++;
        end
        if (cyc >= 200) checkOutput("stream_timeout", 32'(cyc), 32'(n));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int base;

        vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2]  = '{16'h0010, 16'h0003, 1'b1, 16'h000C, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6]  = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[11] = '{16'h00FF, 16'h0001, 1'b1, 16'h00FD, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_result", {14'd0, ovf, bout, d}, 32'd0);
        monEn = 1'b1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

        $display("[TB] back-to-back stream");
        base = outCount;
        runStream(16, 1000, 0, 16'h0000, cyc);
        checkOutput("stream_accept_cycles", 32'(cyc), 32'd16);
        checkOutput("stream_out_count", 32'(outCount - base), 32'd16);

        $display("[TB] stalled stream");
        base = outCount;
        runStream(8, 3, 5, 16'h0A5A, cyc);
        checkOutput("stall_accept_cycles", 32'(cyc), 32'd13);
        checkOutput("stall_out_count", 32'(outCount - base), 32'd8);

        $display("[TB] reset with both stages full");
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h4321;
        b         = 16'h1111;
        @(posedge clk); #1;
        a         = 16'h9999;
        b         = 16'h0123;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        #1;
        checkOutput("full_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_mid_result", {14'd0, ovf, bout, d}, 32'd0);
        base = outCount;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_mid_no_output", 32'(outCount - base), 32'd0);

        applyStimulus(vecs[1], 99);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
